bitrev_reorder_ctrl: RTL and testbench

// - Streaming bit-reversal reorder controller for the NTT datapath.
// - Accepts frames of N = 2**LOG_N coefficients in natural order (valid/ready) and

---
 rtl/bitrev_reorder_ctrl.sv | 107 ++++++++++
 tb/tb_bitrev_reorder_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_reorder_ctrl.sv
// Streaming bit-reversal reorder buffer: frames of 2**LOG_N coefficients enter in
// natural order and leave in bit-reversed order through a two-bank ping-pong store.
module bitrev_reorder_ctrl #(
  parameter int LOG_N  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int N = 1 << LOG_N;

  typedef logic [LOG_N-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  logic [DATA_W-1:0] bank_q [2][N];
  logic [DATA_W-1:0] bank_d [2][N];

  idx_t       wr_idx_q, wr_idx_d;
  idx_t       rd_idx_q, rd_idx_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;

  logic wr_fire, wr_done;
  logic rd_fire, rd_done;

  function automatic idx_t bitrev(input idx_t idx);
    idx_t rev;
    for (int b = 0; b < LOG_N; b++) rev[b] = idx[LOG_N-1-b];
    return rev;
  endfunction

  // Handshakes depend only on registered flags, so ready never combinationally follows ready.
  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];

  assign wr_fire = in_valid && in_ready;
  assign wr_done = wr_fire && (wr_idx_q == LAST_IDX);
  assign rd_fire = out_valid && out_ready;
  assign rd_done = rd_fire && (rd_idx_q == LAST_IDX);

  assign out_data  = out_valid ? bank_q[rd_bank_q][bitrev(rd_idx_q)] : '0;
  assign out_first = out_valid && (rd_idx_q == '0);
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign busy      = (wr_idx_q != '0) || (|full_q);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;

    if (wr_fire) wr_idx_d = wr_idx_q + 1'b1;
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    // The write bank is never full and the read bank always is, so both updates can land on one edge.
    if (rd_fire) rd_idx_d = rd_idx_q + 1'b1;
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (wr_fire) bank_d[wr_bank_q][wr_idx_q] = in_data;
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  // NOTE: storage has no reset; its contents are only observable once a full flag marks them written.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Scoreboard bench for bitrev_reorder_ctrl: a LOG_N=3 instance for the main scenarios
// and a LOG_N=6/DATA_W=16 instance for the wide index reversal.
module tb_bitrev_reorder_ctrl;

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last, busy;
  logic [7:0]  in_data, out_data;

  logic        in_valid6, in_ready6, out_valid6, out_ready6, out_first6, out_last6, busy6;
  logic [15:0] in_data6, out_data6;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   out_cnt = 0, first_cyc = 0, last_cyc = 0;
  int   out_cnt6 = 0;
  logic rand_en = 1'b0;
  logic rdy_force = 1'b0;

  exp_t q0[$];
  exp_t q6[$];
  exp_t e0, e6;

  int br3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  bitrev_reorder_ctrl #(.LOG_N(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  bitrev_reorder_ctrl #(.LOG_N(6), .DATA_W(16)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
    .out_first(out_first6), .out_last(out_last6), .busy(busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // out_ready changes only at posedge+2, so it is stable when the monitor samples at negedge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      out_cnt++;
      if (out_cnt == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0h required=none", out_data);
      end else begin
        e0 = q0.pop_front();
        check("out_data", 32'(out_data), 32'(e0.data));
        check("out_first", 32'(out_first), 32'(e0.first));
        check("out_last", 32'(out_last), 32'(e0.last));
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid6 && out_ready6) begin
      out_cnt6++;
      if (q6.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out6 actual=%0h required=none", out_data6);
      end else begin
        e6 = q6.pop_front();
        check("out_data6", 32'(out_data6), 32'(e6.data));
        check("out_first6", 32'(out_first6), 32'(e6.first));
        check("out_last6", 32'(out_last6), 32'(e6.last));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send0(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
      stall_cnt++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send6(input logic [15:0] d);
    int n;
    n = 0;
    in_valid6 = 1'b1;
    in_data6  = d;
    while (!in_ready6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready6) begin
      checks++;
      errors++;
      $display("FAIL in_ready6_timeout actual=0 required=1");
    end
    @(negedge clk);
    in_valid6 = 1'b0;
  endtask

  task automatic push_frame0(input logic [7:0] d [8]);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.data  = 16'(d[br3[k]]);
      e.first = (k == 0);
      e.last  = (k == 7);
      q0.push_back(e);
    end
  endtask

  task automatic wait_drain0(input string name);
    int n;
    n = 0;
    while (q0.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(q0.size()), 32'd0);
  endtask

  function automatic logic [5:0] bitrev6(input logic [5:0] i);
    logic [5:0] r;
    for (int b = 0; b < 6; b++) r[b] = i[5-b];
    return r;
  endfunction

  initial begin
    logic [7:0] fr [8];
    logic [7:0] fa [8];
    logic [7:0] fb [8];
    exp_t e;
    int n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid6 = 1'b0;
    in_data6  = '0;
    out_ready6 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready6", 32'(in_ready6), 32'd1);

    // Single frame 0..7, latency of first output
    rdy_force = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) fr[i] = 8'(i);
    push_frame0(fr);
    for (int i = 0; i < 7; i++) send0(fr[i]);
    check("single_busy_filling", 32'(busy), 32'd1);
    check("single_valid_before_last", 32'(out_valid), 32'd0);
    send0(fr[7]);
    check("single_valid_after_last", 32'(out_valid), 32'd1);
    wait_drain0("single_drain");
    @(negedge clk);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: 4 frames, no input stalls, no output gaps
    stall_cnt = 0;
    out_cnt   = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = 8'(8'h10 * (f + 1) + i);
      push_frame0(fr);
    end
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++) send0(8'(8'h10 * (f + 1) + i));
    wait_drain0("b2b_drain");
    check("b2b_stalls", 32'(stall_cnt), 32'd0);
    check("b2b_out_count", 32'(out_cnt), 32'd32);
    check("b2b_out_span", 32'(last_cyc - first_cyc), 32'd31);

    // Backpressure: two frames fill both banks
    rdy_force = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      fa[i] = 8'(8'hA0 + i);
      fb[i] = 8'(8'hB0 + i);
    end
    push_frame0(fa);
    push_frame0(fb);
    for (int i = 0; i < 8; i++) send0(fa[i]);
    for (int i = 0; i < 8; i++) send0(fb[i]);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_out_data0", 32'(out_data), 32'(fa[0]));
    check("bp_out_first0", 32'(out_first), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_out_data0_hold", 32'(out_data), 32'(fa[0]));
    check("bp_out_first0_hold", 32'(out_first), 32'd1);
    check("bp_out_valid_hold", 32'(out_valid), 32'd1);
    rdy_force = 1'b1;
    @(negedge clk);
    rdy_force = 1'b0;
    @(negedge clk);
    check("bp_out_data1", 32'(out_data), 32'(fa[4]));
    check("bp_in_ready_after_pulse", 32'(in_ready), 32'd0);
    rdy_force = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_in_ready_draining", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("bp_in_ready_freed", 32'(in_ready), 32'd1);
    wait_drain0("bp_drain");

    // Reset while frame 0 drains and frame 1 is partially written
    for (int i = 0; i < 8; i++) fr[i] = 8'(8'h40 + i);
    push_frame0(fr);
    for (int i = 0; i < 8; i++) send0(fr[i]);
    for (int i = 0; i < 5; i++) send0(8'(8'h50 + i));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) fr[i] = 8'(i);
    push_frame0(fr);
    for (int i = 0; i < 8; i++) send0(fr[i]);
    wait_drain0("mid_rst_drain");

    // Random valid/ready stalls over 100 frames
    out_cnt = 0;
    rand_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = 8'($urandom_range(0, 255));
      push_frame0(fr);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send0(fr[i]);
      end
    end
    wait_drain0("rand_drain");
    rand_en = 1'b0;
    check("rand_out_count", 32'(out_cnt), 32'd800);

    // LOG_N=6, DATA_W=16, data = index
    for (int k = 0; k < 64; k++) begin
      e.data  = 16'(bitrev6(6'(k)));
      e.first = (k == 0);
      e.last  = (k == 63);
      q6.push_back(e);
    end
    check("w6_expect_out1", 32'(q6[1].data), 32'd32);
    check("w6_expect_out2", 32'(q6[2].data), 32'd16);
    for (int k = 0; k < 64; k++) send6(16'(k));
    n = 0;
    while (q6.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("w6_drain", 32'(q6.size()), 32'd0);
    check("w6_out_count", 32'(out_cnt6), 32'd64);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
